clk_div_ctrl: RTL and testbench

Programmable even clock divider with an integrated reconfiguration controller. Two requesters (e.g. the UART baud path and the OV7670 XCLK path) can ask to change the half-period. The block arbitrates round-robin and applies the new ratio only at a full-period boundary, so the divided clock never glitches or loses its 50% duty. Output period = 2*cur_half CLK_IN cycles.

---
 rtl/clk_div_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Even clock divider with a two-requester reconfiguration controller.
// The divided clock runs at 2*cur_half CLK_IN cycles per period. Requester A
// and requester B ask for a new half-period. They are arbitrated round-robin.
// The winning value is applied only on the high->low toggle edge, or at once
// while the divider is stopped. This keeps clk_div free of glitches and at
// 50% duty cycle.
//
// Parameters
//   CNT_W     width of the half-period values and the internal counter
//   DEF_HALF  half-period loaded at reset (1 .. 2**CNT_W-1)
//
// Ports
//   CLK_IN    system clock
//   RST_N     asynchronous active-low reset
//   div_en    1 = divider runs, 0 = divider stopped with clk_div held low
//   req_a     requester A change request, held until gnt_a or nack_a
//   half_a    half-period requested by A
//   gnt_a     one-cycle pulse: A's value has been applied
//   nack_a    one-cycle pulse: A's value was rejected (zero)
//   req_b     requester B change request, held until gnt_b or nack_b
//   half_b    half-period requested by B
//   gnt_b     one-cycle pulse: B's value has been applied
//   nack_b    one-cycle pulse: B's value was rejected (zero)
//   clk_div   divided clock (registered)
//   rise_stb  one-cycle strobe in the first CLK_IN cycle with clk_div high
//
// Optional status ports, present only when CLK_DIV_CTRL_STAT_EN is defined:
//   busy      1 while a reconfiguration is in flight (controller not idle)
//   cur_half  half-period currently applied (DEF_HALF after reset)
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 5
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             div_en,
  input  logic             req_a,
  input  logic [CNT_W-1:0] half_a,
  output logic             gnt_a,
  output logic             nack_a,
  input  logic             req_b,
  input  logic [CNT_W-1:0] half_b,
  output logic             gnt_b,
  output logic             nack_b,
  output logic             clk_div,
  output logic             rise_stb
`ifdef CLK_DIV_CTRL_STAT_EN
  ,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
`endif
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] cur_half_q;
  logic [CNT_W-1:0] pend_half_q;
  logic             clk_div_q;
  logic             rise_q;

  logic             owner_b_q;   // recorded winner of the pending change
  logic             prio_b_q;    // round-robin pointer: 1 favours B
  logic             gnt_a_q, gnt_b_q;
  logic             nack_a_q, nack_b_q;

  logic             last_cnt;
  logic             at_boundary;
  logic             req_a_v, req_b_v;
  logic             win_b;
  logic [CNT_W-1:0] win_half;
  logic             take;
  logic             apply;
  logic             nack_a_d, nack_b_d;

  // The counter is in the last cycle of the current phase.
  assign last_cnt = (count_q == (cur_half_q - ONE));

  // Safe point to switch the ratio: the high->low toggle edge, or any edge
  // while the divider is stopped (clk_div is forced low then anyway).
  assign at_boundary = !div_en || (clk_div_q && last_cnt);

  // ---- controller: next-state and decisions ----
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    apply    = 1'b0;
    nack_a_d = 1'b0;
    nack_b_d = 1'b0;

    // A requester still holds req during its nack cycle. Masking it there
    // stops a single zero request from being rejected twice.
    req_a_v  = req_a && !nack_a_q;
    req_b_v  = req_b && !nack_b_q;
    win_b    = req_b_v && (!req_a_v || prio_b_q);
    win_half = win_b ? half_b : half_a;

    case (state_q)
      IDLE: begin
        if (req_a_v || req_b_v) begin
          if (win_half == '0) begin
            nack_a_d = !win_b;
            nack_b_d = win_b;
          end else begin
            take    = 1'b1;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (at_boundary) begin
          apply   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- controller: state register ----
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      owner_b_q <= 1'b0;
      prio_b_q  <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      nack_a_q  <= 1'b0;
      nack_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      // gnt rises with the ACK state: the requester sees it while the
      // controller is ignoring requests, and drops req before IDLE returns.
      gnt_a_q  <= apply && !owner_b_q;
      gnt_b_q  <= apply && owner_b_q;
      nack_a_q <= nack_a_d;
      nack_b_q <= nack_b_d;

      if (take) begin
        owner_b_q <= win_b;
      end

      // Move the pointer past whoever was served, granted or rejected.
      if (nack_a_d || nack_b_d) begin
        prio_b_q <= nack_a_d;
      end else if (state_q == ACK) begin
        prio_b_q <= !owner_b_q;
      end
    end
  end

  // Pending value is plain data: it is meaningful only while in PEND, and
  // a reset leaves PEND anyway.
  always_ff @(posedge CLK_IN) begin
    if (take) begin
      pend_half_q <= win_half;
    end
  end

  // ---- divider ----
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      count_q    <= '0;
      clk_div_q  <= 1'b0;
      rise_q     <= 1'b0;
      cur_half_q <= RST_HALF;
    end else begin
      rise_q <= 1'b0;
      if (apply) begin
        // The boundary edge behaves like a normal high->low toggle, or like
        // a stopped divider. The output is low in both cases.
        count_q    <= '0;
        clk_div_q  <= 1'b0;
        cur_half_q <= pend_half_q;
      end else if (!div_en) begin
        count_q   <= '0;
        clk_div_q <= 1'b0;
      end else if (last_cnt) begin
        count_q   <= '0;
        clk_div_q <= !clk_div_q;
        rise_q    <= !clk_div_q;
      end else begin
        count_q <= count_q + ONE;
      end
    end
  end

  assign clk_div  = clk_div_q;
  assign rise_stb = rise_q;
  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign nack_a   = nack_a_q;
  assign nack_b   = nack_b_q;

`ifdef CLK_DIV_CTRL_STAT_EN
  assign busy     = (state_q != IDLE);
  assign cur_half = cur_half_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed bench for clk_div_ctrl with the default build (no status ports).
// Each handshake the stimulus issues pushes its expected event code
// ({gnt_a, gnt_b, nack_a, nack_b}) onto a queue. A monitor pops one code for
// every handshake pulse the DUT shows and compares the two. The same monitor
// checks rise_stb against the rising edges of clk_div. The stimulus side
// measures clk_div phase lengths and handshake latencies against values
// worked out by hand.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             CLK_IN = 1'b0;
  logic             RST_N;
  logic             div_en;
  logic             req_a, req_b;
  logic [CNT_W-1:0] half_a, half_b;
  logic             gnt_a, gnt_b, nack_a, nack_b;
  logic             clk_div, rise_stb;

  int               checks = 0;
  int               errors = 0;
  logic [3:0]       exp_q[$];
  logic             prev_clk = 1'b0;

  localparam logic [3:0] EV_GNT_A  = 4'b1000;
  localparam logic [3:0] EV_GNT_B  = 4'b0100;
  localparam logic [3:0] EV_NACK_B = 4'b0001;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(5)) dut (
    .CLK_IN   (CLK_IN),
    .RST_N    (RST_N),
    .div_en   (div_en),
    .req_a    (req_a),
    .half_a   (half_a),
    .gnt_a    (gnt_a),
    .nack_a   (nack_a),
    .req_b    (req_b),
    .half_b   (half_b),
    .gnt_b    (gnt_b),
    .nack_b   (nack_b),
    .clk_div  (clk_div),
    .rise_stb (rise_stb)
  );

  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard side: pops expectations whenever a handshake pulse appears.
  task automatic monitor();
    logic [3:0] ev;
    logic [3:0] want;
    logic       rise_exp;
    forever begin
      @(negedge CLK_IN);
      if (!RST_N) begin
        prev_clk = 1'b0;
      end else begin
        rise_exp = clk_div && !prev_clk;
        if (rise_stb || rise_exp) check("rise_stb", int'(rise_stb), int'(rise_exp));
        prev_clk = clk_div;
      end
      ev = {gnt_a, gnt_b, nack_a, nack_b};
      if (ev != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", int'(ev), 0);
        end else begin
          want = exp_q.pop_front();
          check("handshake_event", int'(ev), int'(want));
        end
      end
    end
  endtask

  task automatic do_reset();
    RST_N  = 1'b0;
    div_en = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    repeat (2) @(negedge CLK_IN);
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_rise_stb", int'(rise_stb), 0);
    check("rst_handshake", int'({gnt_a, gnt_b, nack_a, nack_b}), 0);
    RST_N  = 1'b1;
    div_en = 1'b1;
  endtask

  // Raise a request, hold it until this requester's gnt or nack is seen,
  // then drop it. waited = negedges from raising req to the pulse.
  task automatic hold_req(input bit is_b, input logic [CNT_W-1:0] h, output int waited);
    if (is_b) begin
      req_b  = 1'b1;
      half_b = h;
    end else begin
      req_a  = 1'b1;
      half_a = h;
    end
    waited = 0;
    do begin
      @(negedge CLK_IN);
      waited++;
    end while (!(is_b ? (gnt_b || nack_b) : (gnt_a || nack_a)) && waited < 1000);
    if (waited >= 1000) check("handshake_timeout", waited, 0);
    if (is_b) req_b = 1'b0;
    else      req_a = 1'b0;
  endtask

  // Returns at the negedge of the first high cycle of clk_div.
  task automatic wait_rise();
    int n;
    n = 0;
    do begin
      @(negedge CLK_IN);
      n++;
    end while (!rise_stb && n < 1000);
    if (!rise_stb) check("rise_timeout", n, 0);
  endtask

  // Counts cycles at level lvl, starting with the current negedge sample.
  task automatic meas(input logic lvl, output int n);
    n = 0;
    while (clk_div == lvl && n < 1000) begin
      n++;
      @(negedge CLK_IN);
    end
  endtask

  initial begin
    int h, l, w, w2, n, la, ha;
    RST_N  = 1'b0;
    div_en = 1'b0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    half_a = '0;
    half_b = '0;
    fork
      monitor();
    join_none

    // Default ratio: 5 high / 5 low.
    do_reset();
    wait_rise();
    meas(1'b1, h); check("def_high", h, 5);
    meas(1'b0, l); check("def_low", l, 5);
    meas(1'b1, h); check("def_high2", h, 5);

    // Request 2 in the second high cycle: the high phase completes at 5,
    // gnt appears in the first low cycle, and the new period is 2/2.
    wait_rise();
    @(negedge CLK_IN);
    exp_q.push_back(EV_GNT_A);
    fork
      hold_req(1'b0, 8'd2, w);
      meas(1'b1, h);
    join
    check("mid_high_kept", h + 1, 5);
    check("mid_gnt_latency", w, 4);
    meas(1'b0, l); check("half2_low", l, 2);
    meas(1'b1, h); check("half2_high", h, 2);
    meas(1'b0, l); check("half2_low2", l, 2);

    // Both requesters from reset: A (3) first, then B (7).
    do_reset();
    exp_q.push_back(EV_GNT_A);
    exp_q.push_back(EV_GNT_B);
    fork
      hold_req(1'b0, 8'd3, w);
      hold_req(1'b1, 8'd7, w2);
      begin
        n = 0;
        while (!gnt_a && n < 1000) begin
          @(negedge CLK_IN);
          n++;
        end
        meas(1'b0, la);
        meas(1'b1, ha);
      end
    join
    check("a_first_low", la, 3);
    check("a_first_high", ha, 3);
    meas(1'b0, l); check("b_second_low", l, 7);
    meas(1'b1, h); check("b_second_high", h, 7);

    // Round-robin: B granted last, so A wins; then A granted alone,
    // so B wins the next tie.
    exp_q.push_back(EV_GNT_A);
    exp_q.push_back(EV_GNT_B);
    fork
      hold_req(1'b0, 8'd2, w);
      hold_req(1'b1, 8'd3, w2);
    join
    exp_q.push_back(EV_GNT_A);
    hold_req(1'b0, 8'd4, w);
    exp_q.push_back(EV_GNT_B);
    exp_q.push_back(EV_GNT_A);
    fork
      hold_req(1'b0, 8'd2, w);
      hold_req(1'b1, 8'd3, w2);
    join
    wait_rise();
    meas(1'b1, h); check("rr_final_high", h, 2);
    meas(1'b0, l); check("rr_final_low", l, 2);

    // Zero request from B: nack next cycle, single pulse, ratio unchanged.
    exp_q.push_back(EV_NACK_B);
    hold_req(1'b1, 8'd0, w);
    check("nack_latency", w, 1);
    @(negedge CLK_IN);
    check("nack_one_cycle", int'(nack_b), 0);
    wait_rise();
    meas(1'b1, h); check("after_nack_high", h, 2);
    meas(1'b0, l); check("after_nack_low", l, 2);

    // Stopped divider: grant in the third cycle, then divide by 2.
    div_en = 1'b0;
    @(negedge CLK_IN);
    check("stopped_low", int'(clk_div), 0);
    exp_q.push_back(EV_GNT_A);
    hold_req(1'b0, 8'd1, w);
    check("stopped_gnt_cycle", w + 1, 3);
    div_en = 1'b1;
    wait_rise();
    meas(1'b1, h); check("div2_high", h, 1);
    meas(1'b0, l); check("div2_low", l, 1);
    meas(1'b1, h); check("div2_high2", h, 1);

    // Reset while B's request is pending: no gnt, ratio back to 5.
    exp_q.push_back(EV_GNT_A);
    hold_req(1'b0, 8'd6, w);
    wait_rise();
    repeat (2) @(negedge CLK_IN);
    req_b  = 1'b1;
    half_b = 8'd9;
    @(negedge CLK_IN);
    do_reset();
    wait_rise();
    meas(1'b1, h); check("post_rst_high", h, 5);
    meas(1'b0, l); check("post_rst_low", l, 5);

    // Request equal to the current ratio: granted, no phase disturbance.
    @(negedge CLK_IN);
    exp_q.push_back(EV_GNT_A);
    fork
      hold_req(1'b0, 8'd5, w);
      meas(1'b1, h);
    join
    check("same_high", h + 1, 5);
    check("same_gnt_latency", w, 4);
    meas(1'b0, l); check("same_low", l, 5);
    meas(1'b1, h); check("same_high2", h, 5);

    repeat (5) @(negedge CLK_IN);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
